// File: rtl/rx_bit_serializer_if.sv
// Byte-in / bit-out bundle between the UART receive stage, the serializer and the turbo encoder.
interface rx_bit_serializer_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       bit_out;
  logic       bit_valid;
  logic       bit_ready;
  logic       sob;
  logic       eob;
  logic       fifo_full;
  logic       overflow;

  modport master (
    output byte_in, byte_valid, bit_ready,
    input  bit_out, bit_valid, sob, eob, fifo_full, overflow
  );

  modport slave (
    input  byte_in, byte_valid, bit_ready,
    output bit_out, bit_valid, sob, eob, fifo_full, overflow
  );
endinterface

// File: rtl/rx_bit_serializer.sv
// Byte FIFO feeding an LSB-first bit serializer with block start/end markers.
// Optional macro RX_ZERO_FILTER_EN: discard 8'h00 bytes at the input.
module rx_bit_serializer #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned BLOCK_BYTES = 4
) (
  input  logic                clk,
  input  logic                reset,
  rx_bit_serializer_if.slave  bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [7:0]       LAST_BYTE = 8'(BLOCK_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } state_e;

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  state_e           state_q, state_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       blk_cnt_q, blk_cnt_d;

  logic accept;
  logic push;
  logic pop;
  logic fifo_empty;
  logic fifo_full;

  always_comb begin
`ifdef RX_ZERO_FILTER_EN
    accept = bus.byte_valid && (bus.byte_in != 8'h00);
`else
    accept = bus.byte_valid;
`endif
  end

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);
  // A pop in the same cycle never frees room for a byte arriving while full.
  assign push       = accept && !fifo_full;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q || (accept && fifo_full);
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    blk_cnt_d = blk_cnt_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          shreg_d   = mem_q[rd_ptr_q];
          bit_cnt_d = '0;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        state_d = SHIFT;
      end
      SHIFT: begin
        if (bus.bit_ready) begin
          shreg_d   = {1'b0, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            blk_cnt_d = (blk_cnt_q == LAST_BYTE) ? '0 : blk_cnt_q + 8'd1;
            if (!fifo_empty) begin
              pop       = 1'b1;
              shreg_d   = mem_q[rd_ptr_q];
              bit_cnt_d = '0;
              state_d   = LOAD;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Storage carries no reset; only pointers and occupancy define its contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.byte_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      blk_cnt_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      blk_cnt_q  <= blk_cnt_d;
    end
  end

  assign bus.bit_valid = (state_q == SHIFT);
  assign bus.bit_out   = (state_q == SHIFT) && shreg_q[0];
  assign bus.sob       = (state_q == SHIFT) && (bit_cnt_q == 3'd0) && (blk_cnt_q == '0);
  assign bus.eob       = (state_q == SHIFT) && (bit_cnt_q == 3'd7) && (blk_cnt_q == LAST_BYTE);
  assign bus.fifo_full = fifo_full;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_rx_bit_serializer.sv
// Directed bench for rx_bit_serializer: latency, backpressure, overflow, blocks, reset, zero filter.
module tb_rx_bit_serializer;

  logic clk = 1'b0;
  logic reset;

  rx_bit_serializer_if bus();

  rx_bit_serializer #(
    .DEPTH       (8),
    .BLOCK_BYTES (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  logic cbits [0:255];
  logic csob  [0:255];
  logic ceob  [0:255];
  int   ccount;
  logic ctimeout;

  task automatic do_reset();
    @(negedge clk);
    reset          = 1'b1;
    bus.byte_valid = 1'b0;
    bus.byte_in    = '0;
    bus.bit_ready  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] v);
    bus.byte_valid = 1'b1;
    bus.byte_in    = v;
    @(negedge clk);
    bus.byte_valid = 1'b0;
  endtask

  // Appends n transferred bits to cbits/csob/ceob; bit_ready is left as last driven.
  task automatic collect(input int n, input bit throttle);
    int cyc = 0;
    int got = 0;
    ctimeout = 1'b0;
    while (got < n && cyc < 8 * n + 64) begin
      @(negedge clk);
      cyc++;
      bus.bit_ready = throttle ? (cyc % 3 != 0) : 1'b1;
      if (bus.bit_valid && bus.bit_ready) begin
        cbits[ccount] = bus.bit_out;
        csob[ccount]  = bus.sob;
        ceob[ccount]  = bus.eob;
        ccount++;
        got++;
      end
    end
    if (got < n) ctimeout = 1'b1;
  endtask

  function automatic logic [7:0] get_byte(input int base);
    logic [7:0] v;
    for (int b = 0; b < 8; b++) v[b] = cbits[base + b];
    return v;
  endfunction

  task automatic test_reset();
    logic [5:0] obs;
    do_reset();
    obs = {bus.bit_out, bus.bit_valid, bus.sob, bus.eob, bus.fifo_full, bus.overflow};
    checks++;
    if (obs !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 000000", obs);
    end
  endtask

  task automatic test_single_byte();
    logic [7:0] got;
    logic       all_valid;
    do_reset();
    bus.bit_ready = 1'b1;
    push_byte(8'hA5);
    checks++;
    if (bus.bit_valid !== 1'b0) begin errors++; $display("FAIL lat_edge1 got %b exp 0", bus.bit_valid); end
    @(negedge clk);
    checks++;
    if (bus.bit_valid !== 1'b0) begin errors++; $display("FAIL lat_edge2 got %b exp 0", bus.bit_valid); end
    @(negedge clk);
    checks++;
    if (bus.bit_valid !== 1'b1) begin errors++; $display("FAIL lat_edge3 got %b exp 1", bus.bit_valid); end
    checks++;
    if (bus.sob !== 1'b1) begin errors++; $display("FAIL single_sob got %b exp 1", bus.sob); end
    all_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      got[i] = bus.bit_out;
      if (bus.bit_valid !== 1'b1) all_valid = 1'b0;
    end
    checks++;
    if (all_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", all_valid); end
    checks++;
    if (got !== 8'hA5) begin errors++; $display("FAIL single_data got %h exp a5", got); end
    @(negedge clk);
    checks++;
    if (bus.bit_valid !== 1'b0) begin errors++; $display("FAIL single_end got %b exp 0", bus.bit_valid); end
  endtask

  task automatic test_backpressure();
    logic [7:0] got;
    logic [7:0] exp_b;
    int idx    = 0;
    int stalls = 0;
    int cyc    = 0;
    exp_b = 8'h3C;
    do_reset();
    bus.bit_ready = 1'b1;
    push_byte(exp_b);
    got = '0;
    while (idx < 8 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus.bit_valid) begin
        if (idx == 2 && stalls < 5) begin
          if (stalls > 0) begin
            checks++;
            if ({bus.bit_valid, bus.bit_out, bus.sob, bus.eob} !== 4'b1100) begin
              errors++;
              $display("FAIL bp_hold got %b exp 1100", {bus.bit_valid, bus.bit_out, bus.sob, bus.eob});
            end
          end
          bus.bit_ready = 1'b0;
          stalls++;
        end else begin
          bus.bit_ready = 1'b1;
          got[idx] = bus.bit_out;
          idx++;
        end
      end
    end
    checks++;
    if (idx !== 8) begin errors++; $display("FAIL bp_count got %0d exp 8", idx); end
    checks++;
    if (got !== exp_b) begin errors++; $display("FAIL bp_data got %h exp %h", got, exp_b); end
    @(negedge clk);
    checks++;
    if (bus.bit_valid !== 1'b0) begin errors++; $display("FAIL bp_end got %b exp 0", bus.bit_valid); end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_b;
    do_reset();
    bus.bit_ready = 1'b0;
    push_byte(8'h5A);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.bit_valid !== 1'b1) begin errors++; $display("FAIL ovf_preload got %b exp 1", bus.bit_valid); end
    for (int i = 1; i <= 9; i++) begin
      bus.byte_valid = 1'b1;
      bus.byte_in    = 8'(i * 17);
      @(negedge clk);
      if (i == 7) begin
        checks++;
        if (bus.fifo_full !== 1'b0) begin errors++; $display("FAIL ovf_full7 got %b exp 0", bus.fifo_full); end
      end
      if (i == 8) begin
        checks++;
        if (bus.fifo_full !== 1'b1) begin errors++; $display("FAIL ovf_full8 got %b exp 1", bus.fifo_full); end
        checks++;
        if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_flag8 got %b exp 0", bus.overflow); end
      end
      if (i == 9) begin
        checks++;
        if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag9 got %b exp 1", bus.overflow); end
      end
    end
    bus.byte_valid = 1'b0;
    ccount = 0;
    collect(72, 1'b0);
    checks++;
    if (ctimeout !== 1'b0) begin errors++; $display("FAIL ovf_timeout got %0d bits exp 72", ccount); end
    for (int j = 0; j < 9; j++) begin
      exp_b = (j == 0) ? 8'h5A : 8'(j * 17);
      checks++;
      if (get_byte(8 * j) !== exp_b) begin
        errors++;
        $display("FAIL ovf_byte%0d got %h exp %h", j, get_byte(8 * j), exp_b);
      end
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({bus.bit_valid, bus.fifo_full, bus.overflow} !== 3'b001) begin
      errors++;
      $display("FAIL ovf_after got %b exp 001", {bus.bit_valid, bus.fifo_full, bus.overflow});
    end
  endtask

  task automatic test_blocks();
    logic [7:0] data [0:7];
    logic [1:0] exp_m;
    data = '{8'hC3, 8'h5A, 8'h01, 8'hF0, 8'h96, 8'h7E, 8'h18, 8'hE7};
    do_reset();
    bus.bit_ready = 1'b0;
    for (int j = 0; j < 3; j++) push_byte(data[j]);
    ccount = 0;
    collect(24, 1'b1);
    for (int k = 0; k < 4; k++) @(negedge clk);
    checks++;
    if (bus.bit_valid !== 1'b0) begin errors++; $display("FAIL blk_gap got %b exp 0", bus.bit_valid); end
    bus.bit_ready = 1'b0;
    for (int j = 3; j < 8; j++) push_byte(data[j]);
    collect(40, 1'b1);
    checks++;
    if (ccount !== 64) begin errors++; $display("FAIL blk_count got %0d exp 64", ccount); end
    for (int j = 0; j < 8; j++) begin
      checks++;
      if (get_byte(8 * j) !== data[j]) begin
        errors++;
        $display("FAIL blk_byte%0d got %h exp %h", j, get_byte(8 * j), data[j]);
      end
    end
    for (int i = 0; i < 64; i++) begin
      exp_m = {(i == 0 || i == 32), (i == 31 || i == 63)};
      checks++;
      if ({csob[i], ceob[i]} !== exp_m) begin
        errors++;
        $display("FAIL blk_marker bit %0d got %b exp %b", i, {csob[i], ceob[i]}, exp_m);
      end
    end
  endtask

  task automatic test_mid_block_reset();
    logic [6:0] obs;
    do_reset();
    bus.bit_ready = 1'b0;
    push_byte(8'h10);
    push_byte(8'h20);
    push_byte(8'h30);
    push_byte(8'h40);
    ccount = 0;
    collect(19, 1'b0);
    checks++;
    if ({get_byte(0), get_byte(8)} !== 16'h1020) begin
      errors++;
      $display("FAIL mbr_pre got %h exp 1020", {get_byte(0), get_byte(8)});
    end
    @(negedge clk);
    checks++;
    if (bus.bit_valid !== 1'b1) begin errors++; $display("FAIL mbr_active got %b exp 1", bus.bit_valid); end
    reset = 1'b1;
    @(negedge clk);
    obs = {bus.bit_out, bus.bit_valid, bus.sob, bus.eob, bus.fifo_full, bus.overflow, 1'b0};
    checks++;
    if (obs !== 7'b0) begin errors++; $display("FAIL mbr_zero got %b exp 0000000", obs); end
    reset = 1'b0;
    bus.bit_ready = 1'b0;
    push_byte(8'h81);
    ccount = 0;
    collect(8, 1'b0);
    checks++;
    if (get_byte(0) !== 8'h81) begin errors++; $display("FAIL mbr_data got %h exp 81", get_byte(0)); end
    checks++;
    if ({csob[0], ceob[7]} !== 2'b10) begin errors++; $display("FAIL mbr_sob got %b exp 10", {csob[0], ceob[7]}); end
    for (int k = 0; k < 3; k++) @(negedge clk);
    checks++;
    if (bus.bit_valid !== 1'b0) begin errors++; $display("FAIL mbr_flushed got %b exp 0", bus.bit_valid); end
  endtask

  task automatic test_zero_filter();
    do_reset();
    bus.bit_ready = 1'b0;
    push_byte(8'h00);
    push_byte(8'h41);
    ccount = 0;
`ifdef RX_ZERO_FILTER_EN
    collect(8, 1'b0);
    checks++;
    if (get_byte(0) !== 8'h41) begin errors++; $display("FAIL zf_data got %h exp 41", get_byte(0)); end
    checks++;
    if (csob[0] !== 1'b1) begin errors++; $display("FAIL zf_sob got %b exp 1", csob[0]); end
`else
    collect(16, 1'b0);
    checks++;
    if ({get_byte(0), get_byte(8)} !== 16'h0041) begin
      errors++;
      $display("FAIL zf_data got %h exp 0041", {get_byte(0), get_byte(8)});
    end
    checks++;
    if ({csob[0], csob[8]} !== 2'b10) begin errors++; $display("FAIL zf_sob got %b exp 10", {csob[0], csob[8]}); end
`endif
    for (int k = 0; k < 3; k++) @(negedge clk);
    checks++;
    if ({bus.bit_valid, bus.overflow} !== 2'b00) begin
      errors++;
      $display("FAIL zf_end got %b exp 00", {bus.bit_valid, bus.overflow});
    end
  endtask

  initial begin
    reset          = 1'b1;
    bus.byte_valid = 1'b0;
    bus.byte_in    = '0;
    bus.bit_ready  = 1'b0;
    ccount         = 0;
    ctimeout       = 1'b0;
    test_reset();
    test_single_byte();
    test_backpressure();
    test_overflow();
    test_blocks();
    test_mid_block_reset();
    test_zero_filter();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_bit_serializer.md
RX_BIT_SERIALIZER -- requirements
Module: rx_bit_serializer

Interface
REQ-001 SHALL have parameter DEPTH, default 8: byte FIFO depth, power of two, 2..64.
REQ-002 SHALL have parameter BLOCK_BYTES, default 4: bytes per encoder block, 1..255.
REQ-003 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port byte_in, input, 8: received character from the UART receive stage.
REQ-006 SHALL have port byte_valid, input, 1: one-cycle strobe qualifying byte_in.
REQ-007 SHALL have port bit_out, output, 1: serial data bit to the turbo encoder.
REQ-008 SHALL have port bit_valid, output, 1: bit_out valid.
REQ-009 SHALL have port bit_ready, input, 1: encoder accepts bit_out.
REQ-010 SHALL have port sob, output, 1: high with the first bit of a block.
REQ-011 SHALL have port eob, output, 1: high with the last bit of a block.
REQ-012 SHALL have port fifo_full, output, 1: FIFO holds DEPTH bytes.
REQ-013 SHALL have port overflow, output, 1: sticky flag, a byte was dropped.

Function
REQ-014 SHALL write byte_in into the FIFO on an edge with byte_valid=1 and fifo_full=0.
REQ-015 SHALL drop byte_in and set overflow when byte_valid=1 and fifo_full=1, even if a pop happens the same cycle.
REQ-016 SHALL handle a simultaneous push and pop with the occupancy unchanged and FIFO order preserved.
REQ-017 SHALL wrap the read and write pointers modulo DEPTH and track occupancy 0..DEPTH in a counter of log2(DEPTH)+1 bits.
REQ-018 SHALL implement the serializer FSM states IDLE, LOAD and SHIFT.
REQ-019 SHALL move IDLE->LOAD when the FIFO is non-empty, popping the head byte into an 8-bit shift register.
REQ-020 SHALL move LOAD->SHIFT unconditionally, with bit_valid=1 from SHIFT entry.
REQ-021 SHALL present bits LSB first, a bit transferring on an edge with bit_valid=1 and bit_ready=1.
REQ-022 SHALL hold bit_out, sob and eob stable while bit_valid=1 and bit_ready=0.
REQ-023 SHALL, after the 8th bit transfers, go to LOAD if the FIFO is non-empty, else to IDLE with bit_valid=0.
REQ-024 SHALL give a latency of 2 cycles from byte_valid at edge k (FIFO empty, FSM IDLE) to bit_valid=1 after edge k+2.
REQ-025 SHALL count bytes within a block 0..BLOCK_BYTES-1, wrapping to 0 after the last byte of the block.
REQ-026 SHALL assert sob with bit 0 of byte index 0 and eob with bit 7 of byte index BLOCK_BYTES-1; both high together when BLOCK_BYTES=1.
REQ-027 SHALL, if the FIFO empties mid-block, deassert bit_valid without padding and resume the block with the next byte.

Reset
REQ-028 SHALL, with reset=1 at an edge, clear the FIFO pointers, occupancy, block counter and shift register and set the FSM to IDLE.
REQ-029 SHALL reset outputs bit_out=0, bit_valid=0, sob=0, eob=0, fifo_full=0 and overflow=0.
REQ-030 SHALL make reset take priority over byte_valid and bit_ready, abandoning any partial byte or block.

Configuration
REQ-031 SHALL, with macro RX_ZERO_FILTER_EN defined, discard byte_in==8'h00 at the input, with no FIFO write and no overflow effect.
REQ-032 SHALL, without RX_ZERO_FILTER_EN, treat 8'h00 as ordinary data.

Verification
REQ-033 SHALL check single byte: 8'hA5 strobed, bit_ready=1 -> bit_valid after 2 cycles, bits 1,0,1,0,0,1,0,1, then bit_valid=0.
REQ-034 SHALL check backpressure: 8'h3C with bit_ready low 5 cycles at bit 2 -> bit_out, sob and eob held, sequence unchanged.
REQ-035 SHALL check overflow: DEPTH=8, bit_ready=0, 9 strobes -> fifo_full after the 8th, overflow=1, bytes 1..8 output in order.
REQ-036 SHALL check blocks: BLOCK_BYTES=4, 8 bytes -> sob at bits 0 and 32, eob at bits 31 and 63.
REQ-037 SHALL check mid-block reset: reset asserted at bit 3 of byte 2 -> all outputs zero next cycle, next byte gets sob.
REQ-038 SHALL check the macro: 8'h00, 8'h41 strobed -> with RX_ZERO_FILTER_EN only 8'h41 is serialized, with sob on its bit 0.
